// File: rtl/level_meter_channel_arbiter_pkg.sv
// Shared meter definitions: default level width, channel index helpers and
// the fixed stereo channel numbering.
package level_meter_channel_arbiter_pkg;

    localparam int LEVEL_WIDTH = 16;

    localparam int CH_LEFT  = 0;
    localparam int CH_RIGHT = 1;

    // A single channel still needs one index bit so o_channel is never zero-width.
    function automatic int chan_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/level_meter_channel_arbiter_select.sv
// Round-robin grant search: rotates req so ptr lands at bit 0, takes the lowest
// set bit, then un-rotates the offset back into a channel index.
module round_robin_select
    import level_meter_channel_arbiter_pkg::*;
#(
    parameter int n  = 2,
    parameter int pw = chan_bits(n)
) (
    input  logic [n-1:0]  req,
    input  logic [pw-1:0] ptr,
    output logic [n-1:0]  grant_onehot,
    output logic [pw-1:0] grant_index,
    output logic          any_grant
);

    logic [n-1:0]  rot;
    logic [pw-1:0] off;
    logic [pw:0]   sum;

    always_comb begin
        // Doubling req makes the shift behave as a rotate with no wrap logic.
        rot       = n'({req, req} >> ptr);
        any_grant = |req;
        off       = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (rot[i]) off = pw'(i);
        end
        sum = {1'b0, off} + {1'b0, ptr};
        if (sum >= (pw + 1)'(n)) grant_index = pw'(sum - (pw + 1)'(n));
        else                     grant_index = pw'(sum);
        grant_onehot = '0;
        for (int k = 0; k < n; k++) begin
            grant_onehot[k] = any_grant && (grant_index == pw'(k));
        end
    end

endmodule

// File: rtl/level_meter_channel_arbiter.sv
// Shares one level consumer between several producers: round-robin grant with
// an enable mask, feeding a single registered output stage.
module level_meter_channel_arbiter
    import level_meter_channel_arbiter_pkg::*;
#(
    parameter int   width        = LEVEL_WIDTH,
    parameter int   channels     = 2,
    localparam int  channel_bits = chan_bits(channels)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [channels-1:0]       i_enable,
    input  logic [channels-1:0]       i_valid,
    output logic [channels-1:0]       i_ready,
    input  logic [channels*width-1:0] i_value,
    output logic                      o_valid,
    input  logic                      o_ready,
    output logic [channel_bits-1:0]   o_channel,
    output logic [width-1:0]          o_value
);

    logic [channel_bits-1:0] ptr;
    logic [channel_bits-1:0] grant_index;
    logic [channels-1:0]     req;
    logic [channels-1:0]     grant_onehot;
    logic                    any_grant;
    logic                    free;
    logic                    xfer;
    logic [width-1:0]        sel_value;

    assign req  = i_valid & i_enable;
    assign free = !o_valid || o_ready;
    assign xfer = any_grant && free;

    // Held low during reset so no producer believes a handshake completed.
    assign i_ready = (free && !reset) ? grant_onehot : '0;

    round_robin_select #(
        .n  (channels),
        .pw (channel_bits)
    ) u_select (
        .req          (req),
        .ptr          (ptr),
        .grant_onehot (grant_onehot),
        .grant_index  (grant_index),
        .any_grant    (any_grant)
    );

    always_comb begin
        sel_value = '0;
        for (int k = 0; k < channels; k++) begin
            if (grant_index == channel_bits'(k)) sel_value = i_value[k*width +: width];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_valid   <= 1'b0;
            o_value   <= '0;
            o_channel <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            o_valid   <= 1'b1;
            o_value   <= sel_value;
            o_channel <= grant_index;
            ptr       <= (grant_index == channel_bits'(channels - 1)) ? '0
                                                                      : grant_index + 1'b1;
        end else if (o_ready) begin
            o_valid   <= 1'b0;
        end
    end

endmodule
